// File: rtl/sync_bank.sv
// sync_bank: multi-channel input conditioning for asynchronous pins.
// Each channel runs through a STAGES-deep synchronizer chain, an optional
// debounce filter, and a registered rise/fall edge detector.
// Compile-time option: define SYNC_BANK_DEBOUNCE_EN to build the per-channel
// debounce counters. Without it, out is the last chain flop and
// DEBOUNCE_CYCLES is unused.
module sync_bank #(
    parameter int   WIDTH           = 4,
    parameter int   STAGES          = 2,
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_edge
);

    if (WIDTH < 1) begin : g_bad_width
        $error("sync_bank: WIDTH must be at least 1");
    end
    if (STAGES < 2) begin : g_bad_stages
        $error("sync_bank: STAGES must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("sync_bank: DEBOUNCE_CYCLES must be at least 1");
    end

    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] lvl_d;
    logic [WIDTH-1:0] lvl_q;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic             any_edge_q;
`ifndef SYNC_BANK_DEBOUNCE_EN
    logic [WIDTH-1:0] sync_d;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        logic [STAGES-1:0] s_q;

        // Shift the raw pin into the chain; only s_q[0] may go metastable.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_q <= {STAGES{RESET_VAL}};
            end else begin
                s_q <= {s_q[STAGES-2:0], in[i]};
            end
        end

        assign sync_q[i] = s_q[STAGES-1];
`ifndef SYNC_BANK_DEBOUNCE_EN
        // Next value of sync_q. With STAGES=2 this taps s_q[0]; that read is
        // what lets the pulse line up with out at STAGES edges of latency.
        assign sync_d[i] = s_q[STAGES-2];
`endif
    end

`ifdef SYNC_BANK_DEBOUNCE_EN
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_deb
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             out_nxt;

        // Count consecutive disagreeing cycles; commit the new level on the last one.
        always_comb begin
            cnt_d   = cnt_q;
            out_nxt = out_q[i];
            if (sync_q[i] == out_q[i]) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                out_nxt = sync_q[i];
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // Stability counter; reset discards any partial count.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign out_d[i] = out_nxt;
    end

    // Debounced output level register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= {WIDTH{RESET_VAL}};
        end else begin
            out_q <= out_d;
        end
    end

    assign out   = out_q;
    assign lvl_d = out_d;
    assign lvl_q = out_q;
`else
    assign out   = sync_q;
    assign lvl_d = sync_d;
    assign lvl_q = sync_q;
`endif

    // Edge pulses compare next level with current so they land on the edge out changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q     <= '0;
            fall_q     <= '0;
            any_edge_q <= 1'b0;
        end else begin
            rise_q     <= lvl_d & ~lvl_q;
            fall_q     <= ~lvl_d & lvl_q;
            any_edge_q <= |(lvl_d ^ lvl_q);
        end
    end

    assign rise     = rise_q;
    assign fall     = fall_q;
    assign any_edge = any_edge_q;

endmodule

// File: tb/tb_sync_bank.sv
// Testbench for sync_bank with default parameters (WIDTH=4, STAGES=2,
// DEBOUNCE_CYCLES=4). Expected timings follow SYNC_BANK_DEBOUNCE_EN.
module tb_sync_bank;

`ifdef SYNC_BANK_DEBOUNCE_EN
    localparam int LAT     = 6;   // STAGES + DEBOUNCE_CYCLES
    localparam int B_RISE  = 0;   // rises during the bounce burst
    localparam int B_FALL  = 0;
    localparam int HOLD_E  = 6;   // rise edge after the final hold begins
`else
    localparam int LAT     = 2;   // STAGES
    localparam int B_RISE  = 5;
    localparam int B_FALL  = 5;
    localparam int HOLD_E  = 2;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] in0 = '0;
    logic [3:0] in1 = '0;
    logic [3:0] out0, rise0, fall0;
    logic [3:0] out1, rise1, fall1;
    logic       any0, any1;

    always #5 clk = ~clk;

    sync_bank #(.WIDTH(4), .STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_VAL(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .in(in0),
        .out(out0), .rise(rise0), .fall(fall0), .any_edge(any0)
    );

    sync_bank #(.WIDTH(4), .STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_VAL(1'b1)) dut_rv1 (
        .clk(clk), .rst_n(rst_n), .in(in1),
        .out(out1), .rise(rise1), .fall(fall1), .any_edge(any1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in0   = '0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    // One pulse of len cycles on channel ch, applied right after reset release.
    typedef struct {
        int ch;
        int len;
        int nrise;
        int rise_e;
        int nfall;
        int fall_e;
        int out_end;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int         ch, nr, nf, re, fe, abad, obad, na, nb, last;
        logic       exp_any;
        logic [3:0] mask, rv, fv, rel;

`ifdef SYNC_BANK_DEBOUNCE_EN
        vecs[0] = '{0, 1000, 1, 6, 0,  0, 1};
        vecs[1] = '{1,    3, 0, 0, 0,  0, 0};
        vecs[2] = '{1,    4, 1, 6, 1, 10, 0};
        vecs[3] = '{3,    1, 0, 0, 0,  0, 0};
        vecs[4] = '{2,    8, 1, 6, 1, 14, 0};
        vecs[5] = '{3,    5, 1, 6, 1, 11, 0};
`else
        vecs[0] = '{0, 1000, 1, 2, 0,  0, 1};
        vecs[1] = '{1,    3, 1, 2, 1,  5, 0};
        vecs[2] = '{1,    4, 1, 2, 1,  6, 0};
        vecs[3] = '{3,    1, 1, 2, 1,  3, 0};
        vecs[4] = '{2,    8, 1, 2, 1, 10, 0};
        vecs[5] = '{3,    5, 1, 2, 1,  7, 0};
`endif

        // Reset state, sampled while reset is held.
        rst_n = 1'b0;
        repeat (3) tick();
        check("reset out0", out0, 4'h0);
        check("reset out1", out1, 4'hF);
        check("reset pulses0", {rise0, fall0, 3'b000, any0}, 12'h000);
        check("reset pulses1", {rise1, fall1, 3'b000, any1}, 12'h000);

        // Table-driven pulses.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            ch   = vecs[v].ch;
            mask = 4'b0001 << ch;
            in0  = mask;
            nr = 0; nf = 0; re = 0; fe = 0; abad = 0; obad = 0;
            for (int e = 1; e <= 20; e++) begin
                tick();
                if (rise0[ch]) begin nr++; if (re == 0) re = e; end
                if (fall0[ch]) begin nf++; if (fe == 0) fe = e; end
                exp_any = (vecs[v].nrise > 0 && e == vecs[v].rise_e) ||
                          (vecs[v].nfall > 0 && e == vecs[v].fall_e);
                if (any0 !== exp_any) abad++;
                if (((out0 | rise0 | fall0) & ~mask) != 4'h0) obad++;
                if (e == vecs[v].len) in0 = '0;
            end
            check($sformatf("vec%0d rise count", v), nr, vecs[v].nrise);
            check($sformatf("vec%0d rise edge", v), re, vecs[v].rise_e);
            check($sformatf("vec%0d fall count", v), nf, vecs[v].nfall);
            check($sformatf("vec%0d fall edge", v), fe, vecs[v].fall_e);
            check($sformatf("vec%0d final out", v), out0[ch], vecs[v].out_end);
            check($sformatf("vec%0d any_edge bad cycles", v), abad, 0);
            check($sformatf("vec%0d other channel activity", v), obad, 0);
        end

        // RESET_VAL=1 instance: async assert, then release with in low.
        in0   = '0;
        rst_n = 1'b0;
        #1;
        check("async reset out1", out1, 4'hF);
        repeat (2) tick();
        check("held reset out1", out1, 4'hF);
        rst_n = 1'b1;
        fe = 0; nf = 0; na = 0; fv = '0; rel = '0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (e == 1) rel = rise1 | fall1 | {3'b000, any1};
            if (fall1 != 4'h0) begin nf++; if (fe == 0) begin fe = e; fv = fall1; end end
            if (any1) na++;
        end
        check("rv1 release-edge pulse", rel, 4'h0);
        check("rv1 fall edge", fe, LAT);
        check("rv1 fall value", fv, 4'hF);
        check("rv1 fall cycles", nf, 1);
        check("rv1 any_edge cycles", na, 1);
        check("rv1 final out", out1, 4'h0);

        // Release with all inputs high: no pulse at the release edge.
        rst_n = 1'b0;
        in0   = 4'hF;
        repeat (2) tick();
        rst_n = 1'b1;
        rel = '0; re = 0; rv = '0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (e == 1) rel = rise0 | fall0 | {3'b000, any0};
            if (rise0 != 4'h0 && re == 0) begin re = e; rv = rise0; end
        end
        check("release high pulse", rel, 4'h0);
        check("release high rise edge", re, LAT);
        check("release high rise value", rv, 4'hF);

        // Simultaneous edges on two channels.
        do_reset();
        repeat (3) tick();
        in0 = 4'b1010;
        nr = 0; re = 0; rv = '0; na = 0; nb = 0;
        for (int e = 1; e <= 15; e++) begin
            tick();
            if (rise0 != 4'h0) begin nr++; re = e; rv = rise0; end
            if (any0) na++;
            if (fall0 != 4'h0) nb++;
        end
        check("simul rise cycles", nr, 1);
        check("simul rise edge", re, LAT);
        check("simul rise value", rv, 4'b1010);
        check("simul any_edge cycles", na, 1);
        check("simul fall cycles", nb, 0);

        // Bounce: in[2] toggles every 2 cycles for 20 cycles, then holds high.
        do_reset();
        nr = 0; nf = 0;
        for (int c = 0; c < 20; c++) begin
            in0[2] = ((c / 2) % 2 == 0);
            tick();
            if (rise0[2]) nr++;
            if (fall0[2]) nf++;
        end
        check("bounce rises", nr, B_RISE);
        check("bounce falls", nf, B_FALL);
        in0[2] = 1'b1;
        nr = 0; last = 0;
        for (int e = 1; e <= 15; e++) begin
            tick();
            if (rise0[2]) begin nr++; last = e; end
        end
        check("hold rise count", nr, 1);
        check("hold rise edge", last, HOLD_E);

        // Reset two cycles into a debounce; the change restarts after release.
        do_reset();
        in0[0] = 1'b1;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check("midreset out", out0, 4'h0);
        check("midreset rise", rise0, 4'h0);
        repeat (2) tick();
        check("midreset held out", out0, 4'h0);
        rst_n = 1'b1;
        nr = 0; re = 0;
        for (int e = 1; e <= 15; e++) begin
            tick();
            if (rise0[0]) begin nr++; if (re == 0) re = e; end
        end
        check("midreset rise edge", re, LAT);
        check("midreset rise count", nr, 1);
        check("midreset final out", out0, 4'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
